// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage register result scoreboard with late-result stall
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_d,
    input  logic            flush_d,
    input  logic            freeze,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic            use1,
    input  logic            use2,
    input  logic [4:0]      dst,
    input  logic            regwrite,
    input  logic            late,
    input  logic            ready_valid,
    input  logic [4:0]      ready_dst,
    input  logic            commit_valid,
    input  logic [4:0]      commit_dst,
    output logic            stall_d,
    output logic            issue,
    output logic            busy,
    output logic [NREG-1:0] pending
);

    logic [CNTW-1:0] cnt [NREG];
    logic [NREG-1:0] lt;

    logic            raw1;
    logic            raw2;
    logic            full;
    logic [NREG-1:0] incVec;
    logic [NREG-1:0] decVec;
    logic [NREG-1:0] rdyVec;

    // Only a not-yet-forwardable youngest writer blocks a reader; plain in-flight writers are forwarded.
    always_comb begin
        raw1    = use1 && (ra1 != 5'd0) && lt[ra1];
        raw2    = use2 && (ra2 != 5'd0) && lt[ra2];
        full    = regwrite && (dst != 5'd0) && (cnt[dst] == '1);
        stall_d = valid_d && !flush_d && (raw1 || raw2 || full);
        issue   = valid_d && !flush_d && !freeze && !stall_d;
    end

    always_comb begin
        incVec = '0;
        decVec = '0;
        rdyVec = '0;
        pending = '0;
        for (int r = 1; r < NREG; r++) begin
            incVec[r]  = issue && regwrite && (dst == 5'(r));
            decVec[r]  = commit_valid && (commit_dst == 5'(r)) && (cnt[r] != '0);
            rdyVec[r]  = ready_valid && (ready_dst == 5'(r));
            pending[r] = (cnt[r] != '0);
        end
        busy = |pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            lt <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (incVec[r] && !decVec[r]) begin
                    cnt[r] <= cnt[r] + CNTW'(1);
                end else if (decVec[r] && !incVec[r]) begin
                    cnt[r] <= cnt[r] - CNTW'(1);
                end
                // A new writer always wins over a same-edge ready or final commit.
                if (incVec[r]) begin
                    lt[r] <= late;
                end else if (decVec[r] && (cnt[r] == CNTW'(1))) begin
                    lt[r] <= 1'b0;
                end else if (rdyVec[r]) begin
                    lt[r] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed table-driven bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d, flush_d, freeze;
    logic [4:0]  ra1, ra2, dst, ready_dst, commit_dst;
    logic        use1, use2, regwrite, late, ready_valid, commit_valid;
    logic        stall_d, issue, busy;
    logic [31:0] pending;

    int checks = 0;
    int failures = 0;

    hazard_scoreboard #(.NREG(32), .CNTW(2)) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .flush_d(flush_d), .freeze(freeze),
        .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2), .dst(dst), .regwrite(regwrite),
        .late(late), .ready_valid(ready_valid), .ready_dst(ready_dst),
        .commit_valid(commit_valid), .commit_dst(commit_dst),
        .stall_d(stall_d), .issue(issue), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic vd, fl, fz;
        logic [4:0] a1; logic u1;
        logic [4:0] a2; logic u2;
        logic [4:0] d; logic rw, lt;
        logic rv; logic [4:0] rd;
        logic cv; logic [4:0] cd;
        logic eStall, eIssue;
        logic [31:0] ePend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic vd, fl, fz, input logic [4:0] a1, input logic u1,
                                input logic [4:0] a2, input logic u2, input logic [4:0] d,
                                input logic rw, lt, rv, input logic [4:0] rd, input logic cv,
                                input logic [4:0] cd, input logic es, ei, input logic [31:0] ep);
        vec_t v;
        v.vd = vd; v.fl = fl; v.fz = fz; v.a1 = a1; v.u1 = u1; v.a2 = a2; v.u2 = u2;
        v.d = d; v.rw = rw; v.lt = lt; v.rv = rv; v.rd = rd; v.cv = cv; v.cd = cd;
        v.eStall = es; v.eIssue = ei; v.ePend = ep;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        valid_d = v.vd; flush_d = v.fl; freeze = v.fz;
        ra1 = v.a1; use1 = v.u1; ra2 = v.a2; use2 = v.u2;
        dst = v.d; regwrite = v.rw; late = v.lt;
        ready_valid = v.rv; ready_dst = v.rd; commit_valid = v.cv; commit_dst = v.cd;
    endtask

    task automatic idle();
        drive(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic es, input logic ei, input logic [31:0] ep);
        chk({tag, " stall_d"}, {31'd0, stall_d}, {31'd0, es});
        chk({tag, " issue"}, {31'd0, issue}, {31'd0, ei});
        chk({tag, " pending"}, pending, ep);
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, |ep});
    endtask

    // Commits to a register with no outstanding writer are legal but noted.
    always @(posedge clk) begin
        if (!reset && commit_valid && commit_dst != 5'd0 && !pending[commit_dst])
            $display("note: commit to idle x%0d ignored", commit_dst);
    end

    initial begin
        reset = 1'b1;
        idle();
        valid_d = 1'b1;
        #2;
        chkAll("reset", 1'b0, 1'b1, 32'h0);

        //      vd fl fz a1 u1 a2 u2 d  rw lt rv rd cv cd  stall issue pend
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,  0,0,32'h0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 5,1,1, 0,0, 0,0,  0,1,32'h0));
        tbl.push_back(mk(1,0,0, 5,1, 0,0, 6,1,0, 0,0, 0,0,  1,0,32'h20));
        tbl.push_back(mk(1,0,0, 5,1, 0,0, 6,1,0, 1,5, 0,0,  1,0,32'h20));
        tbl.push_back(mk(1,0,0, 5,1, 0,0, 6,1,0, 0,0, 0,0,  0,1,32'h20));
        tbl.push_back(mk(1,0,0, 0,0, 6,1, 0,0,0, 0,0, 1,5,  0,1,32'h60));
        tbl.push_back(mk(1,0,0, 6,1, 0,0, 0,0,0, 0,0, 1,6,  0,1,32'h40));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,  0,0,32'h0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  0,1,32'h0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  0,1,32'h8));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  0,1,32'h8));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  1,0,32'h8));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 1,3,  0,0,32'h8));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 1,3,  0,1,32'h8));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  0,1,32'h8));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  1,0,32'h8));
        tbl.push_back(mk(1,1,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  0,0,32'h8));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 0,0,0, 0,0, 1,3,  0,0,32'h8));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 3,1,0, 0,0, 0,0,  0,1,32'h8));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 1,3,  0,0,32'h8));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 1,3,  0,0,32'h8));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 1,3,  0,0,32'h8));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,  0,0,32'h0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,1,1, 0,0, 0,0,  0,1,32'h0));
        tbl.push_back(mk(1,0,0, 0,1, 0,1, 0,0,0, 1,0, 1,0,  0,1,32'h0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,  0,0,32'h0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 1,10, 0,0,32'h0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0,10,1,0, 0,0, 0,0,  0,1,32'h0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,  0,0,32'h400));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 1,10, 0,0,32'h400));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,  0,0,32'h0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0,11,1,1, 0,0, 0,0,  0,1,32'h0));
        tbl.push_back(mk(1,0,0,11,0,11,0, 0,0,0, 0,0, 0,0,  0,1,32'h800));
        tbl.push_back(mk(1,0,0, 0,0,11,1, 0,0,0, 0,0, 0,0,  1,0,32'h800));
        tbl.push_back(mk(1,0,0, 0,0,11,1, 0,0,0, 0,0, 1,11, 1,0,32'h800));
        tbl.push_back(mk(1,0,0, 0,0,11,1, 0,0,0, 0,0, 0,0,  0,1,32'h0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0,12,1,1, 0,0, 0,0,  0,1,32'h0));
        tbl.push_back(mk(1,0,1,12,1, 0,0, 0,0,0, 1,12,0,0,  1,0,32'h1000));
        tbl.push_back(mk(1,0,0,12,1, 0,0, 0,0,0, 0,0, 0,0,  0,1,32'h1000));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 1,12, 0,0,32'h1000));
        tbl.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0,  0,0,32'h0));

        @(negedge clk);
        reset = 1'b0;
        idle();

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chkAll($sformatf("v%0d", i), tbl[i].eStall, tbl[i].eIssue, tbl[i].ePend);
        end

        // Late writer to x9 issues on the same edge that a ready for x9 arrives.
        @(negedge clk);
        drive(mk(1,0,0, 0,0, 0,0, 9,1,1, 1,9, 0,0, 0,0,0));
        #1;
        chkAll("same_edge issue", 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        drive(mk(1,0,0, 9,1, 0,0, 0,0,0, 0,0, 0,0, 0,0,0));
        #1;
        chkAll("same_edge reader", 1'b1, 1'b0, 32'h200);
        @(negedge clk);
        drive(mk(1,0,0, 9,1, 0,0, 0,0,0, 1,9, 0,0, 0,0,0));
        #1;
        chkAll("same_edge ready", 1'b1, 1'b0, 32'h200);
        @(negedge clk);
        drive(mk(1,0,0, 9,1, 0,0, 0,0,0, 0,0, 1,9, 0,0,0));
        #1;
        chkAll("same_edge release", 1'b0, 1'b1, 32'h200);

        // Async reset in the middle of a load-use stall with two writers to x5.
        @(negedge clk);
        drive(mk(1,0,0, 0,0, 0,0, 5,1,1, 0,0, 0,0, 0,0,0));
        @(negedge clk);
        drive(mk(1,0,0, 0,0, 0,0, 5,1,1, 0,0, 0,0, 0,0,0));
        #1;
        chkAll("rst pre2", 1'b0, 1'b1, 32'h20);
        @(negedge clk);
        drive(mk(1,0,0, 5,1, 0,0, 0,0,0, 0,0, 0,0, 0,0,0));
        #1;
        chkAll("rst stall", 1'b1, 1'b0, 32'h20);
        #1;
        reset = 1'b1;
        #1;
        chkAll("rst async", 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chkAll("rst after", 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chkAll("rst idle", 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
